i2s_rx_sync: RTL

I2S_RX_SYNC -- requirements
Module: i2s_rx_sync

---
 rtl/i2s_rx_sync.sv | 110 +++++++++++
 1 files changed

// File: rtl/i2s_rx_sync.sv
// I2S / left-justified stereo receiver: synchronises the audio pins into clk,
// assembles left/right samples and hands each complete frame over a valid/ready port.
module i2s_rx_sync #(
  parameter int DATA_W   = 24,
  parameter int MODE     = 0,
  parameter int MIN_SLOT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              audio_bclk,
  input  logic              audio_lrclk,
  input  logic              audio_sdata,
  output logic [DATA_W-1:0] out_ldata,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam logic [5:0]        SLOT_DATA_W = 6'(DATA_W);
  localparam logic [5:0]        SLOT_MIN    = 6'(MIN_SLOT);
  localparam logic [DATA_W-1:0] TOP_BIT     = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        bclk_sync, lrclk_sync, sdata_sync;
  logic              bclk_prev;
  logic              lr_delay, steer_prev, seen_left;
  logic [5:0]        lcnt, rcnt;
  logic [DATA_W-1:0] lshift, rshift;

  logic              bit_event, steer, slot_end, frame_done, short_slot;
  logic [5:0]        end_cnt, cur_cnt, next_cnt;
  logic [DATA_W-1:0] cur_data, next_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], audio_bclk};
      lrclk_sync <= {lrclk_sync[0], audio_lrclk};
      sdata_sync <= {sdata_sync[0], audio_sdata};
      bclk_prev  <= bclk_sync[1];
    end
  end

  // In I2S mode the first bit after an LRCLK edge is still the previous slot's LSB,
  // so the slot select lags the sampled LRCLK by one bit event.
  always_comb begin
    bit_event  = bclk_sync[1] & ~bclk_prev;
    steer      = (MODE == 0) ? lr_delay : lrclk_sync[1];
    slot_end   = steer ^ steer_prev;
    frame_done = slot_end & steer_prev;
    end_cnt    = steer_prev ? rcnt : lcnt;
    short_slot = (end_cnt < SLOT_DATA_W) || (end_cnt < SLOT_MIN);
    cur_cnt    = slot_end ? 6'd0 : (steer ? rcnt : lcnt);
    cur_data   = steer ? rshift : lshift;
    next_data  = (cur_cnt == 6'd0) ? '0 : cur_data;
    if (sdata_sync[1]) next_data = next_data | (TOP_BIT >> cur_cnt);
    next_cnt   = (cur_cnt == 6'd63) ? cur_cnt : cur_cnt + 6'd1;
  end

  // Slots whose start was not observed since reset are neither checked nor delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_delay   <= 1'b0;
      steer_prev <= 1'b0;
      seen_left  <= 1'b0;
      lcnt       <= '0;
      rcnt       <= '0;
      lshift     <= '0;
      rshift     <= '0;
      out_ldata  <= '0;
      out_rdata  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (bit_event) begin
        lr_delay   <= lrclk_sync[1];
        steer_prev <= steer;
        if (steer) begin
          rshift <= next_data;
          rcnt   <= next_cnt;
          if (slot_end) lcnt <= '0;
        end else begin
          lshift <= next_data;
          lcnt   <= next_cnt;
          if (slot_end) rcnt <= '0;
        end
        if (slot_end && seen_left && short_slot) frame_err <= 1'b1;
        if (frame_done) begin
          seen_left <= 1'b1;
          if (seen_left) begin
            out_ldata <= lshift;
            out_rdata <= rshift;
            out_valid <= 1'b1;
            overrun   <= out_valid & ~out_ready;
          end
        end
      end
    end
  end

endmodule
